// File: rtl/lsu_axil_master.sv
// lsu_axil_master: converts one RV32I load/store request into a single AXI4-Lite
// transaction, with byte-lane steering on stores and sign/zero extension on loads.
// Exactly one transaction is in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for LSU_REQ; request fields are latched on accept
// S_WR    | AWVALID/WVALID asserted, each held until its own handshake
// S_BRESP | BREADY high, waiting for the write response
// S_RADDR | ARVALID high until ARREADY; RREADY already high
// S_RDATA | RREADY high, waiting for read data
// S_FIN   | LSU_DONE (and LSU_ERR) high for this single cycle
module lsu_axil_master #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic                    LSU_REQ,
  input  logic                    LSU_WE,
  input  logic [2:0]              LSU_FUNCT3,
  input  logic [31:0]             LSU_ADDR,
  input  logic [31:0]             LSU_WDATA,
  output logic                    LSU_BUSY,
  output logic                    LSU_DONE,
  output logic                    LSU_ERR,
  output logic [31:0]             LSU_RDATA,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_BRESP,
    S_RADDR,
    S_RDATA,
    S_FIN
  } state_t;

  state_t      state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;

  logic        req_bad;
  logic [31:0] wdata_lanes;
  logic [3:0]  wstrb_lanes;
  logic [31:0] load_lane;
  logic [31:0] load_data;

  // Byte-address bits above the word index never reach the bus.
  logic unused_addr_hi;
  assign unused_addr_hi = ^LSU_ADDR[31:AXI_AWIDTH+2];

  // Reject misaligned halves/words and funct3 codes that are illegal for the direction.
  always_comb begin
    req_bad = 1'b1;
    case (LSU_FUNCT3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = LSU_ADDR[0];
      3'b010:  req_bad = (LSU_ADDR[1:0] != 2'b00);
      3'b100:  req_bad = LSU_WE;
      3'b101:  req_bad = LSU_WE | LSU_ADDR[0];
      default: req_bad = 1'b1;
    endcase
  end

  // Replicate store data across lanes and build the matching byte strobe.
  always_comb begin
    wdata_lanes = LSU_WDATA;
    wstrb_lanes = 4'b1111;
    case (LSU_FUNCT3[1:0])
      2'b00: begin
        wdata_lanes = {4{LSU_WDATA[7:0]}};
        wstrb_lanes = 4'b0001 << LSU_ADDR[1:0];
      end
      2'b01: begin
        wdata_lanes = {2{LSU_WDATA[15:0]}};
        wstrb_lanes = 4'b0011 << {LSU_ADDR[1], 1'b0};
      end
      default: begin
        wdata_lanes = LSU_WDATA;
        wstrb_lanes = 4'b1111;
      end
    endcase
  end

  // Shift the addressed lane down and extend it according to the latched funct3.
  always_comb begin
    load_lane = AXI_RDATA >> {addr_lo_q, 3'b000};
    load_data = AXI_RDATA;
    case (funct3_q)
      3'b000:  load_data = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_data = {24'h000000, load_lane[7:0]};
      3'b101:  load_data = {16'h0000, load_lane[15:0]};
      default: load_data = AXI_RDATA;
    endcase
  end

  // Transaction FSM; every bus and LSU output is registered here.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state       <= S_IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      LSU_BUSY    <= 1'b0;
      LSU_DONE    <= 1'b0;
      LSU_ERR     <= 1'b0;
      LSU_RDATA   <= '0;
      AXI_AWADDR  <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARADDR  <= '0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
    end else begin
      LSU_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (LSU_REQ) begin
            addr_lo_q <= LSU_ADDR[1:0];
            funct3_q  <= LSU_FUNCT3;
            LSU_BUSY  <= 1'b1;
            if (req_bad) begin
              LSU_DONE <= 1'b1;
              LSU_ERR  <= 1'b1;
              state    <= S_FIN;
            end else if (LSU_WE) begin
              AXI_AWADDR  <= LSU_ADDR[AXI_AWIDTH+1:2];
              AXI_WDATA   <= wdata_lanes;
              AXI_WSTRB   <= wstrb_lanes;
              AXI_AWVALID <= 1'b1;
              AXI_WVALID  <= 1'b1;
              state       <= S_WR;
            end else begin
              AXI_ARADDR  <= LSU_ADDR[AXI_AWIDTH+1:2];
              AXI_ARVALID <= 1'b1;
              AXI_RREADY  <= 1'b1;
              state       <= S_RADDR;
            end
          end
        end

        S_WR: begin
          // A channel whose VALID is already low has completed its handshake.
          if (AXI_AWVALID && AXI_AWREADY) AXI_AWVALID <= 1'b0;
          if (AXI_WVALID && AXI_WREADY) AXI_WVALID <= 1'b0;
          if ((!AXI_AWVALID || AXI_AWREADY) && (!AXI_WVALID || AXI_WREADY)) begin
            AXI_BREADY <= 1'b1;
            state      <= S_BRESP;
          end
        end

        S_BRESP: begin
          if (AXI_BVALID) begin
            AXI_BREADY <= 1'b0;
            LSU_ERR    <= |AXI_BRESP;
            LSU_DONE   <= 1'b1;
            state      <= S_FIN;
          end
        end

        S_RADDR: begin
          if (AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            if (AXI_RVALID) begin
              AXI_RREADY <= 1'b0;
              LSU_RDATA  <= load_data;
              LSU_ERR    <= |AXI_RRESP;
              LSU_DONE   <= 1'b1;
              state      <= S_FIN;
            end else begin
              state <= S_RDATA;
            end
          end
        end

        S_RDATA: begin
          if (AXI_RVALID) begin
            AXI_RREADY <= 1'b0;
            LSU_RDATA  <= load_data;
            LSU_ERR    <= |AXI_RRESP;
            LSU_DONE   <= 1'b1;
            state      <= S_FIN;
          end
        end

        S_FIN: begin
          LSU_ERR  <= 1'b0;
          LSU_BUSY <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          LSU_BUSY <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
